// File: rtl/uart_cmd_pwm.sv
// UART command parser driving a bank of PWM channels.
// Frames: 'S' ch duty -> 'K'; 'G' ch -> shadow duty; anything malformed -> 'E'.

module pwm_lane #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PWM_BITS-1:0] cnt,
  input  logic                wrap,
  input  logic                wr_en,
  input  logic [PWM_BITS-1:0] wr_data,
  output logic [PWM_BITS-1:0] shadow,
  output logic                pwm
);
  logic [PWM_BITS-1:0] active;

  // active samples shadow before a same-edge write lands, so new duty waits a period
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow <= '0;
      active <= '0;
      pwm    <= 1'b0;
    end else begin
      if (wr_en) shadow <= wr_data;
      if (wrap)  active <= shadow;
      pwm <= (cnt < active);
    end
  end
endmodule

module uart_cmd_pwm #(
  parameter int NUM_CH         = 3,
  parameter int PWM_BITS       = 8,
  parameter int TIMEOUT_CYCLES = 4_800_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rcv_data,
  input  logic              rcv_ready,
  input  logic              snd_busy,
  output logic [7:0]        snd_data,
  output logic              snd_ready,
  output logic [NUM_CH-1:0] pwm_out
);
  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] OP_SET  = 8'h53;
  localparam logic [7:0] OP_GET  = 8'h47;
  localparam logic [7:0] RSP_ERR = 8'h45;
  localparam logic [7:0] RSP_OK  = 8'h4B;

  typedef enum logic [1:0] {IDLE, GET_CH, GET_DUTY, RESP} state_t;

  state_t state, state_nx;
  logic          op_set, op_nx;
  logic [2:0]    ch, ch_nx;
  logic [7:0]    resp, resp_nx;
  logic          wr_go, send_go;
  logic [GW-1:0] gap;
  logic          timeout;

  logic [PWM_BITS-1:0]              cnt;
  logic                             wrap;
  logic [NUM_CH-1:0][PWM_BITS-1:0]  shadow;
  logic [NUM_CH-1:0]                wr_en;
  logic [7:0][7:0]                  rd_tab;

  assign wrap    = (cnt == '1);
  assign timeout = (gap == GW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else        cnt <= cnt + 1'b1;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    assign wr_en[i] = wr_go && (ch == 3'(i));
    pwm_lane #(.PWM_BITS(PWM_BITS)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .cnt     (cnt),
      .wrap    (wrap),
      .wr_en   (wr_en[i]),
      .wr_data (rcv_data[PWM_BITS-1:0]),
      .shadow  (shadow[i]),
      .pwm     (pwm_out[i])
    );
  end

  // zero-extended readback table, padded to 8 entries so a 3-bit index is always legal
  always_comb begin
    rd_tab = '0;
    for (int i = 0; i < NUM_CH; i++) rd_tab[i][PWM_BITS-1:0] = shadow[i];
  end

  always_comb begin
    state_nx = state;
    op_nx    = op_set;
    ch_nx    = ch;
    resp_nx  = resp;
    wr_go    = 1'b0;
    send_go  = 1'b0;
    case (state)
      IDLE: if (rcv_ready) begin
        if (rcv_data == OP_SET || rcv_data == OP_GET) begin
          op_nx    = (rcv_data == OP_SET);
          state_nx = GET_CH;
        end else begin
          resp_nx  = RSP_ERR;
          state_nx = RESP;
        end
      end
      GET_CH: if (rcv_ready) begin
        if (rcv_data >= 8'(NUM_CH)) begin
          resp_nx  = RSP_ERR;
          state_nx = RESP;
        end else if (op_set) begin
          ch_nx    = rcv_data[2:0];
          state_nx = GET_DUTY;
        end else begin
          resp_nx  = rd_tab[rcv_data[2:0]];
          state_nx = RESP;
        end
      end else if (timeout) state_nx = IDLE;
      GET_DUTY: if (rcv_ready) begin
        wr_go    = 1'b1;
        resp_nx  = RSP_OK;
        state_nx = RESP;
      end else if (timeout) state_nx = IDLE;
      RESP: if (!snd_busy) begin
        send_go  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      op_set    <= 1'b0;
      ch        <= '0;
      resp      <= '0;
      gap       <= '0;
      snd_data  <= '0;
      snd_ready <= 1'b0;
    end else begin
      state     <= state_nx;
      op_set    <= op_nx;
      ch        <= ch_nx;
      resp      <= resp_nx;
      snd_ready <= send_go;
      if (send_go) snd_data <= resp;
      // gap only runs while a frame is partially received
      if ((state == GET_CH || state == GET_DUTY) && !rcv_ready && !timeout) gap <= gap + 1'b1;
      else                                                                gap <= '0;
    end
  end
endmodule
